// File: rtl/lsu_mem_arbiter_pkg.sv
// Shared GPU types: data words, data-memory addresses and the
// LSU memory arbiter state encoding.
package gpu_defines;

  typedef logic [31:0] data_t;
  typedef logic [31:0] data_memory_address_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_RD_WAIT,
    ARB_WR_WAIT,
    ARB_RESPOND
  } arb_state_t;

endpackage

// File: rtl/lsu_mem_arbiter_if.sv
// LSU-side request/response bundle plus the single memory channel.
// slave: arbiter view; master: LSU/memory environment view.
interface lsu_mem_arbiter_if
  import gpu_defines::*;
#(
  parameter int NUM_REQ = 17
);

  logic                 [NUM_REQ-1:0] lsu_read_valid;
  data_memory_address_t [NUM_REQ-1:0] lsu_read_address;
  logic                 [NUM_REQ-1:0] lsu_read_ready;
  data_t                [NUM_REQ-1:0] lsu_read_data;

  logic                 [NUM_REQ-1:0] lsu_write_valid;
  data_memory_address_t [NUM_REQ-1:0] lsu_write_address;
  data_t                [NUM_REQ-1:0] lsu_write_data;
  logic                 [NUM_REQ-1:0] lsu_write_ready;

  logic                 mem_read_valid;
  data_memory_address_t mem_read_address;
  logic                 mem_read_ready;
  data_t                mem_read_data;

  logic                 mem_write_valid;
  data_memory_address_t mem_write_address;
  data_t                mem_write_data;
  logic                 mem_write_ready;

  modport slave (
    input  lsu_read_valid, lsu_read_address,
    output lsu_read_ready, lsu_read_data,
    input  lsu_write_valid, lsu_write_address,
    input  lsu_write_data,
    output lsu_write_ready,
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address,
    output mem_write_data,
    input  mem_write_ready
  );

  modport master (
    output lsu_read_valid, lsu_read_address,
    input  lsu_read_ready, lsu_read_data,
    output lsu_write_valid, lsu_write_address,
    output lsu_write_data,
    input  lsu_write_ready,
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address,
    input  mem_write_data,
    output mem_write_ready
  );

endinterface

// File: rtl/lsu_mem_arbiter_picker.sv
// rr_priority_picker: first set request strictly after ptr_i, wrapping.
// Ports: req_i, ptr_i in; gnt_o (one-hot), idx_o, any_o out.
module rr_priority_picker #(
  parameter int N = 17,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    logic [IW:0]   s;
    logic [IW-1:0] j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    s     = '0;
    j     = '0;
    for (int i = 1; i <= N; i++) begin
      // ptr_i < N and i <= N, so one subtraction is a full modulo
      s = {1'b0, ptr_i} + (IW+1)'(i);
      if (s >= (IW+1)'(N)) s = s - (IW+1)'(N);
      j = s[IW-1:0];
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        idx_o    = j;
        gnt_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter: NUM_REQ LSUs onto one read and one write channel.
// Ports: clk, reset (async, high), bus (slave view), busy.
module lsu_mem_arbiter
  import gpu_defines::*;
#(
  parameter int NUM_REQ = 17
) (
  input  logic             clk,
  input  logic             reset,
  lsu_mem_arbiter_if.slave bus,
  output logic             busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ - 1);

  arb_state_t           state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        gnt_q, gnt_d;
  logic                 wr_q, wr_d;
  data_memory_address_t addr_q, addr_d;
  data_t                wdata_q, wdata_d;
  data_t                rdata_q, rdata_d;
  logic                 mrv_q, mrv_d;
  logic                 mwv_q, mwv_d;

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 pick_wr;

  assign req = bus.lsu_read_valid | bus.lsu_write_valid;

  rr_priority_picker #(
    .N(NUM_REQ)
  ) u_pick (
    .req_i(req),
    .ptr_i(ptr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );

  // a winner holding both requests is served write-first
  assign pick_wr = |(pick_gnt & bus.lsu_write_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      ptr_q   <= PTR_RST;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mrv_q   <= 1'b0;
      mwv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mrv_q   <= mrv_d;
      mwv_q   <= mwv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mrv_d   = mrv_q;
    mwv_d   = mwv_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_idx;
          wr_d    = pick_wr;
          wdata_d = bus.lsu_write_data[pick_idx];
          if (pick_wr) begin
            addr_d  = bus.lsu_write_address[pick_idx];
            mwv_d   = 1'b1;
            state_d = ARB_WR_WAIT;
          end else begin
            addr_d  = bus.lsu_read_address[pick_idx];
            mrv_d   = 1'b1;
            state_d = ARB_RD_WAIT;
          end
        end
      end
      ARB_RD_WAIT: begin
        if (bus.mem_read_ready) begin
          rdata_d = bus.mem_read_data;
          mrv_d   = 1'b0;
          state_d = ARB_RESPOND;
        end
      end
      ARB_WR_WAIT: begin
        if (bus.mem_write_ready) begin
          mwv_d   = 1'b0;
          state_d = ARB_RESPOND;
        end
      end
      ARB_RESPOND: begin
        ptr_d   = gnt_q;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  logic [NUM_REQ-1:0] rd_rdy;
  logic [NUM_REQ-1:0] wr_rdy;
  data_t [NUM_REQ-1:0] rd_data;

  always_comb begin
    rd_rdy  = '0;
    wr_rdy  = '0;
    rd_data = '0;
    if (state_q == ARB_RESPOND) begin
      if (wr_q) begin
        wr_rdy[gnt_q] = 1'b1;
      end else begin
        rd_rdy[gnt_q]  = 1'b1;
        rd_data[gnt_q] = rdata_q;
      end
    end
  end

  assign bus.lsu_read_ready    = rd_rdy;
  assign bus.lsu_write_ready   = wr_rdy;
  assign bus.lsu_read_data     = rd_data;
  assign bus.mem_read_valid    = mrv_q;
  assign bus.mem_read_address  = addr_q;
  assign bus.mem_write_valid   = mwv_q;
  assign bus.mem_write_address = addr_q;
  assign bus.mem_write_data    = wdata_q;
  assign busy                  = (state_q != ARB_IDLE);

endmodule
